// File: rtl/ssr_read_arbiter.sv
// rtl/ssr_read_arbiter.sv - round-robin arbiter and SPI burst sequencer for the SSR byte source
//
// Shares one SPI byte source between NUM_REQ distribution units. The granted unit gets one
// chip-select-framed burst of up to BURST_LEN bytes, each delivered over a 4-phase
// byte_ready / byte_received_ack handshake.
//
// Ports:
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   readssr_req         per-unit burst request, held for the whole burst
//   byte_received_ack   per-unit byte acknowledge (level, 4-phase)
//   byte_ready          per-unit byte valid, only the granted bit can be set
//   byte_out            shared byte data, valid while byte_ready is set
//   grant               one-hot burst owner, zero when idle
//   spi_cs_n            SPI chip select, low for the whole burst
//   spi_start           one-cycle pulse starting a byte transfer
//   spi_tx              constant transmit byte
//   spi_done, spi_rx    transfer-complete pulse and received byte

module ssr_read_arbiter #(
  parameter int         NUM_REQ   = 2,
  parameter int         BURST_LEN = 40,
  parameter logic [7:0] TX_BYTE   = 8'h00,
  parameter int         CS_SETUP  = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] readssr_req,
  input  logic [NUM_REQ-1:0] byte_received_ack,
  output logic [NUM_REQ-1:0] byte_ready,
  output logic [7:0]         byte_out,
  output logic [NUM_REQ-1:0] grant,
  output logic               spi_cs_n,
  output logic               spi_start,
  output logic [7:0]         spi_tx,
  input  logic               spi_done,
  input  logic [7:0]         spi_rx
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = $clog2(BURST_LEN + 1);
  localparam int SW = (CS_SETUP > 1) ? $clog2(CS_SETUP) : 1;

  // The transfer state is entered together with the spi_start pulse, so the cycle in which
  // spi_start is high already belongs to the wait for spi_done. This gives the one-cycle
  // ack-low to spi_start latency without a separate issue state.
  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_WAIT_DONE,
    S_PRESENT,
    S_ACK_LOW,
    S_RELEASE
  } state_t;

  state_t          state;
  logic [IW-1:0]   own;         // index of the granted unit
  logic [IW-1:0]   rr_ptr;      // highest-priority unit for the next arbitration
  logic [CW-1:0]   count;       // bytes completed in this burst
  logic [SW-1:0]   setup_cnt;
  logic            abort_pend;  // owner dropped its request while a transfer was in flight

  logic            own_req;
  logic            own_ack;
  logic            pick_valid;
  logic [IW-1:0]   pick_idx;
  logic [IW-1:0]   cand;
  int              sum;

  assign spi_tx  = TX_BYTE;
  assign own_req = readssr_req[own];
  assign own_ack = byte_received_ack[own];

  // Round-robin pick: scan offsets from the highest down so the lowest offset from rr_ptr
  // that is requesting wins.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    sum        = 0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      sum = int'(rr_ptr) + i;
      if (sum >= NUM_REQ) begin
        sum = sum - NUM_REQ;
      end
      cand = IW'(sum);
      if (readssr_req[cand]) begin
        pick_valid = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      own        <= '0;
      rr_ptr     <= '0;
      count      <= '0;
      setup_cnt  <= '0;
      abort_pend <= 1'b0;
      byte_ready <= '0;
      byte_out   <= '0;
      grant      <= '0;
      spi_cs_n   <= 1'b1;
      spi_start  <= 1'b0;
    end else begin
      spi_start <= 1'b0;
      case (state)
        S_IDLE: begin
          if (pick_valid) begin
            own       <= pick_idx;
            grant     <= NUM_REQ'(1) << pick_idx;
            spi_cs_n  <= 1'b0;
            count     <= '0;
            setup_cnt <= '0;
            state     <= S_SETUP;
          end
        end

        S_SETUP: begin
          if (!own_req) begin
            state <= S_RELEASE;
          end else if (setup_cnt == SW'(CS_SETUP - 1)) begin
            spi_start  <= 1'b1;
            abort_pend <= 1'b0;
            state      <= S_WAIT_DONE;
          end else begin
            setup_cnt <= setup_cnt + SW'(1);
          end
        end

        // A transfer cannot be cancelled on the SPI side, so an abort waits for spi_done
        // and then throws the byte away.
        S_WAIT_DONE: begin
          if (spi_done) begin
            if (abort_pend || !own_req) begin
              state <= S_RELEASE;
            end else begin
              byte_out   <= spi_rx;
              byte_ready <= grant;
              state      <= S_PRESENT;
            end
          end else if (!own_req) begin
            abort_pend <= 1'b1;
          end
        end

        S_PRESENT: begin
          if (own_ack) begin
            byte_ready <= '0;
            count      <= count + CW'(1);
            state      <= S_ACK_LOW;
          end
        end

        S_ACK_LOW: begin
          if (!own_ack) begin
            if ((count == CW'(BURST_LEN)) || !own_req) begin
              state <= S_RELEASE;
            end else begin
              spi_start  <= 1'b1;
              abort_pend <= 1'b0;
              state      <= S_WAIT_DONE;
            end
          end
        end

        // cs_n rises here and IDLE needs at least one cycle, so cs_n is high for at least
        // one cycle between bursts.
        S_RELEASE: begin
          spi_cs_n <= 1'b1;
          grant    <= '0;
          rr_ptr   <= (own == IW'(NUM_REQ - 1)) ? '0 : own + IW'(1);
          state    <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ssr_read_arbiter.sv
// tb/tb_ssr_read_arbiter.sv - bench for ssr_read_arbiter

module tb_ssr_read_arbiter;

  localparam int N  = 2;
  localparam int BL = 40;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] readssr_req;
  logic [N-1:0] byte_received_ack;
  logic [N-1:0] byte_ready;
  logic [7:0]   byte_out;
  logic [N-1:0] grant;
  logic         spi_cs_n;
  logic         spi_start;
  logic [7:0]   spi_tx;
  logic         spi_done;
  logic [7:0]   spi_rx;

  ssr_read_arbiter #(
    .NUM_REQ  (N),
    .BURST_LEN(BL),
    .TX_BYTE  (8'h00),
    .CS_SETUP (2)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .readssr_req      (readssr_req),
    .byte_received_ack(byte_received_ack),
    .byte_ready       (byte_ready),
    .byte_out         (byte_out),
    .grant            (grant),
    .spi_cs_n         (spi_cs_n),
    .spi_start        (spi_start),
    .spi_tx           (spi_tx),
    .spi_done         (spi_done),
    .spi_rx           (spi_rx)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // reference model state
  int         cyc = 0;
  int         exp_rr;
  int         owner;
  int         cur_kind;      // 0 full burst, 1 drop at ack low after cur_n, 2 drop in transfer after cur_n
  int         cur_n;
  int         starts;
  int         bursts = 0;
  int         exp_ready_cyc;
  int         exp_start_cyc;
  logic [N-1:0] prev_grant;
  logic [7:0] q[$];
  logic [7:0] next_byte;
  logic [7:0] held;
  bit         spi_busy;
  bit         xfer_abort;
  int         spi_dly;
  int         req_mode[N];   // 0 no re-request, 1 always request, 2 random
  int         plan_kind[N];
  int         plan_n[N];
  int         phase[N];
  int         wait_c[N];
  int         hold_c[N];
  int         recv[N];
  bit         just_acked[N];
  bit         fixed_tim = 0;
  bit         rand_drop = 0;
  bit         spur_ack  = 0;
  bit         force_done;
  bit         rst_arm;
  bit         rst_hit;
  int         rst_byte = 0;

  function automatic logic [N-1:0] onehot(input int i);
    onehot = '0;
    if (i >= 0) onehot[i] = 1'b1;
  endfunction

  function automatic int predict(input logic [N-1:0] r, input int rr);
    for (int k = 0; k < N; k++) begin
      if (r[(rr + k) % N]) return (rr + k) % N;
    end
    return -1;
  endfunction

  task automatic init_model();
    exp_rr = 0; owner = -1; cur_kind = 0; cur_n = BL; starts = 0;
    exp_ready_cyc = -1; exp_start_cyc = -1; prev_grant = '0;
    q.delete(); next_byte = 8'h00; spi_busy = 0; xfer_abort = 0; spi_dly = 0;
    force_done = 0; rst_arm = 0; rst_hit = 0;
    for (int u = 0; u < N; u++) begin
      plan_kind[u] = -1; plan_n[u] = 0; phase[u] = 0; wait_c[u] = 0;
      hold_c[u] = 0; recv[u] = 0; just_acked[u] = 0;
    end
  endtask

  task automatic check_reset_outputs(input string pfx);
    check_eq({pfx, "_byte_ready"}, 32'(byte_ready), 0);
    check_eq({pfx, "_grant"},      32'(grant), 0);
    check_eq({pfx, "_byte_out"},   32'(byte_out), 0);
    check_eq({pfx, "_cs_n"},       32'(spi_cs_n), 1);
    check_eq({pfx, "_spi_start"},  32'(spi_start), 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    readssr_req = '0; byte_received_ack = '0; spi_done = 1'b0; spi_rx = 8'h00;
    init_model();
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
  endtask

  // One clock of the bench: observe at the falling edge, run the models, drive new inputs.
  task automatic step();
    logic [N-1:0] rq, ak;
    logic         dn;
    logic [7:0]   rx;
    int           pred, u;
    @(negedge clk);
    cyc++;
    rq = readssr_req; ak = byte_received_ack; dn = 1'b0; rx = spi_rx;

    check_eq("grant_onehot0", 32'($onehot0(grant)), 1);
    check_eq("ready_outside_grant", 32'(byte_ready & ~grant), 0);
    check_eq("cs_n_follows_grant", 32'(spi_cs_n), 32'(grant == '0));
    check_eq("spi_tx_const", 32'(spi_tx), 0);
    if (exp_start_cyc == cyc) check_eq("start_latency", 32'(spi_start), 1);
    if (exp_ready_cyc == cyc) check_eq("done_to_ready", 32'(byte_ready), 32'(onehot(owner)));

    if (prev_grant == '0 && grant != '0) begin
      pred = predict(rq, exp_rr);
      check_eq("rr_grant", 32'(grant), 32'(onehot(pred)));
      owner = pred;
      if (owner >= 0) begin
        recv[owner] = 0; phase[owner] = 0; just_acked[owner] = 0; starts = 0;
        if (plan_kind[owner] >= 0) begin
          cur_kind = plan_kind[owner]; cur_n = plan_n[owner]; plan_kind[owner] = -1;
        end else if (rand_drop && $urandom_range(0, 3) == 0) begin
          cur_kind = 1; cur_n = $urandom_range(1, BL - 1);
        end else begin
          cur_kind = 0; cur_n = BL;
        end
        exp_start_cyc = cyc + 2;
      end
    end else if (prev_grant != '0 && grant == '0) begin
      if (owner >= 0) begin
        check_eq("burst_bytes", recv[owner], (cur_kind == 0) ? BL : cur_n);
        check_eq("burst_starts", starts, (cur_kind == 2) ? cur_n + 1 : ((cur_kind == 0) ? BL : cur_n));
        exp_rr = (owner + 1) % N;
        if (req_mode[owner] != 1) rq[owner] = 1'b0;
      end
      bursts++;
      owner = -1;
    end else if (prev_grant != '0) begin
      check_eq("grant_stable", 32'(grant), 32'(prev_grant));
    end

    if (owner < 0) begin
      check_eq("idle_no_start", 32'(spi_start), 0);
      check_eq("idle_no_ready", 32'(byte_ready), 0);
    end else if (spi_start) begin
      starts++;
    end

    if (owner >= 0) begin
      u = owner;
      if (phase[u] == 2) begin
        if (just_acked[u]) begin
          check_eq("ack_to_ready_low", 32'(byte_ready[u]), 0);
          just_acked[u] = 0;
        end
        if (hold_c[u] > 0) begin
          hold_c[u]--;
        end else if (!byte_ready[u]) begin
          ak[u] = 1'b0;
          phase[u] = 0;
          if (cur_kind == 1 && recv[u] == cur_n) rq[u] = 1'b0;
          else if (recv[u] < BL) exp_start_cyc = cyc + 1;
        end
      end else if (phase[u] == 1) begin
        check_eq("ready_held", 32'(byte_ready[u]), 1);
        check_eq("data_held", 32'(byte_out), 32'(held));
      end else if (byte_ready[u]) begin
        if (q.size() == 0) check_eq("unexpected_byte", 32'(byte_ready[u]), 0);
        else check_eq("byte_data", 32'(byte_out), 32'(q.pop_front()));
        held = byte_out;
        recv[u]++;
        if (rst_arm && recv[u] == rst_byte) rst_hit = 1;
        wait_c[u] = fixed_tim ? 5 : $urandom_range(0, 4);
        phase[u] = 1;
      end
      if (phase[u] == 1) begin
        if (wait_c[u] == 0) begin
          ak[u] = 1'b1;
          hold_c[u] = fixed_tim ? 2 : $urandom_range(0, 2);
          just_acked[u] = 1;
          phase[u] = 2;
        end else begin
          wait_c[u]--;
        end
      end
      if (cur_kind == 2 && spi_start && recv[u] == cur_n) rq[u] = 1'b0;
    end

    for (int v = 0; v < N; v++) begin
      if (v != owner) begin
        if (!rq[v] && (req_mode[v] == 1 || (req_mode[v] == 2 && $urandom_range(0, 7) == 0)))
          rq[v] = 1'b1;
        ak[v] = (!rq[v] && spur_ack) ? 1'($urandom_range(0, 1)) : 1'b0;
      end
    end

    // SPI slave: answers each start after a short delay with the next byte of a counter
    if (spi_start) begin
      check_eq("start_while_busy", 32'(spi_busy), 0);
      spi_busy = 1; xfer_abort = 0;
      spi_dly = fixed_tim ? 2 : $urandom_range(0, 3);
    end
    if (spi_busy && owner >= 0 && !rq[owner]) xfer_abort = 1;
    if (force_done) begin
      dn = 1'b1; rx = 8'hA5;
    end else if (spi_busy) begin
      if (spi_dly == 0) begin
        dn = 1'b1; rx = next_byte; next_byte++; spi_busy = 0;
        if (!xfer_abort && owner >= 0 && rq[owner]) begin
          q.push_back(rx);
          exp_ready_cyc = cyc + 1;
        end
      end else begin
        spi_dly--;
      end
    end

    readssr_req = rq; byte_received_ack = ak; spi_done = dn; spi_rx = rx;
    prev_grant = grant;
  endtask

  task automatic run_until(input int nb, input int budget);
    int t0;
    t0 = cyc;
    while (bursts < nb && (cyc - t0) < budget && !rst_hit) step();
    if (!rst_hit) check_eq("burst_timeout", bursts, nb);
  endtask

  task automatic quiesce();
    req_mode[0] = 0; req_mode[1] = 0;
    readssr_req = '0;
    repeat (3) step();
  endtask

  initial begin
    rst = 1'b1;
    readssr_req = '0; byte_received_ack = '0; spi_done = 1'b0; spi_rx = 8'h00;
    req_mode[0] = 0; req_mode[1] = 0;
    init_model();
    #1 check_reset_outputs("por");
    do_reset();

    // single unit, full burst of 0x00..0x27
    readssr_req = 2'b01;
    run_until(bursts + 1, 3000);
    check_eq("t1_spi_bytes", 32'(next_byte), 40);
    quiesce();

    // contention from reset, then round-robin alternation
    do_reset();
    req_mode[0] = 1; req_mode[1] = 1;
    readssr_req = 2'b11;
    run_until(bursts + 4, 8000);
    quiesce();

    // slow handshake: ack after 5 cycles, held 3 cycles
    fixed_tim = 1;
    readssr_req = 2'b01;
    run_until(bursts + 1, 6000);
    fixed_tim = 0;
    quiesce();

    // abort after the 10th ack, then abort while a transfer is in flight
    plan_kind[0] = 1; plan_n[0] = 10;
    readssr_req = 2'b01;
    run_until(bursts + 1, 3000);
    quiesce();
    plan_kind[0] = 2; plan_n[0] = 5;
    readssr_req = 2'b01;
    run_until(bursts + 1, 3000);
    quiesce();

    // asynchronous reset while presenting byte 20, then unit 1 takes a full burst
    rst_arm = 1; rst_byte = 20;
    readssr_req = 2'b01;
    run_until(bursts + 1, 3000);
    check_eq("rst_trigger_reached", 32'(rst_hit), 1);
    #2 rst = 1'b1;
    #1 check_reset_outputs("async_reset");
    readssr_req = 2'b10; byte_received_ack = '0; spi_done = 1'b0;
    init_model();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    run_until(bursts + 1, 3000);
    quiesce();

    // spurious spi_done while idle, then spurious acks from the idle unit during a burst
    force_done = 1;
    step();
    force_done = 0;
    repeat (4) step();
    check_eq("spurious_done_no_grant", 32'(grant), 0);
    spur_ack = 1;
    readssr_req = 2'b01;
    run_until(bursts + 1, 3000);
    quiesce();

    // random traffic
    req_mode[0] = 2; req_mode[1] = 2;
    rand_drop = 1;
    run_until(bursts + 30, 40000);
    quiesce();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
